// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-access stage between the LC-3 control unit (ISDU) and an async
//   SRAM. Turns the ISDU's level-sensitive Mem_OE / Mem_WE strobes plus
//   MAR / MDR into sequenced active-low SRAM cycles with WAIT_CYCLES wait
//   states. It returns registered read data (MDR_In) and a one-cycle
//   Mem_Ready completion pulse.
//
// Ports
//   Clk, Reset          clock; synchronous active-low reset
//   Mem_OE, Mem_WE      read / write request levels from ISDU (write wins)
//   MAR, MDR            word address / write data
//   Data_from_SRAM      resolved SRAM read bus
//   SRAM_ADDR           latched address, MAR zero-extended
//   SRAM_*_N            active-low SRAM controls (CE, OE, WE, UB, LB)
//   Data_to_SRAM        latched write data
//   Data_drive_en       tristate enable for Data_to_SRAM
//   MDR_In              registered read data
//   Mem_Ready           one-cycle completion pulse
//   Busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,   // 1..15
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [DATA_W-1:0] MAR,
    input  logic [DATA_W-1:0] MDR,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_drive_en,
    output logic [DATA_W-1:0] MDR_In,
    output logic              Mem_Ready,
    output logic              Busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RELEASE
    } state_e;

    localparam logic [4:0] WAIT_L = 5'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Count of the cycle currently in progress (1..WAIT_CYCLES); one bit
    // wider than the counter so WAIT_CYCLES=15 cannot wrap.
    logic [4:0] cnt_inc;
    logic       last_cycle;

    assign cnt_inc    = {1'b0, cnt_q} + 5'd1;
    assign last_cycle = (cnt_inc >= WAIT_L);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic. Strobes are only looked at in IDLE and RELEASE, so a
    // started access always runs to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (Mem_WE) begin
                    state_d = WR_SETUP;
                    addr_d  = ADDR_W'(MAR);
                    wdata_d = MDR;
                end else if (Mem_OE) begin
                    state_d = RD_ACT;
                    addr_d  = ADDR_W'(MAR);
                end
            end
            RD_ACT: begin
                cnt_d = cnt_inc[3:0];
                if (last_cycle) begin
                    rdata_d = Data_from_SRAM;
                    state_d = RD_DONE;
                end
            end
            RD_DONE:  state_d = RELEASE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                cnt_d = cnt_inc[3:0];
                if (last_cycle) state_d = WR_HOLD;
            end
            WR_HOLD:  state_d = RELEASE;
            RELEASE: begin
                // Wait for the ISDU to drop its level so that one assertion
                // yields exactly one SRAM access.
                if (!Mem_OE && !Mem_WE) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // The counter restarts on every state entry.
        if (state_d != state_q) cnt_d = '0;
    end

    // Moore output decode from the state register only.
    always_comb begin
        SRAM_CE_N     = 1'b1;
        SRAM_OE_N     = 1'b1;
        SRAM_WE_N     = 1'b1;
        SRAM_UB_N     = 1'b1;
        SRAM_LB_N     = 1'b1;
        Data_drive_en = 1'b0;
        Mem_Ready     = 1'b0;
        Busy          = (state_q != IDLE);

        unique case (state_q)
            RD_ACT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            RD_DONE: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                Mem_Ready = 1'b1;
            end
            WR_SETUP: begin
                SRAM_CE_N     = 1'b0;
                SRAM_UB_N     = 1'b0;
                SRAM_LB_N     = 1'b0;
                Data_drive_en = 1'b1;
            end
            WR_PULSE: begin
                SRAM_CE_N     = 1'b0;
                SRAM_WE_N     = 1'b0;
                SRAM_UB_N     = 1'b0;
                SRAM_LB_N     = 1'b0;
                Data_drive_en = 1'b1;
            end
            WR_HOLD: begin
                SRAM_CE_N     = 1'b0;
                SRAM_UB_N     = 1'b0;
                SRAM_LB_N     = 1'b0;
                Data_drive_en = 1'b1;
                Mem_Ready     = 1'b1;
            end
            default: ;
        endcase
    end

    assign SRAM_ADDR    = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign MDR_In       = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. Three instances (WAIT_CYCLES = 1, 2, 15) share
// one stimulus stream. The driver pushes the expected completion of every
// accepted request into a per-instance queue. A per-instance monitor pops on
// each Mem_Ready and checks latency, address, data and strobe pulse widths.
module tb_mem_access_ctrl;

    localparam int NI = 3;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
        int          acc;   // cycle count at the negedge the request was driven
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;

    logic [15:0] s_dfs   [NI];
    logic [19:0] s_addr  [NI];
    logic        s_ce    [NI];
    logic        s_oe    [NI];
    logic        s_we    [NI];
    logic        s_ub    [NI];
    logic        s_lb    [NI];
    logic [15:0] s_dts   [NI];
    logic        s_de    [NI];
    logic [15:0] s_mdr   [NI];
    logic        s_rdy   [NI];
    logic        s_busy  [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wof(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
    endfunction

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference memory: what every read should return.
    logic [15:0] mmem [65536];
    bit          mwr  [65536];

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mwr[a] ? mmem[a] : dflt(a);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 2 : 15);

        mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) u_dut (
            .Clk(clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
            .MAR(MAR), .MDR(MDR), .Data_from_SRAM(s_dfs[g]),
            .SRAM_ADDR(s_addr[g]), .SRAM_CE_N(s_ce[g]), .SRAM_OE_N(s_oe[g]),
            .SRAM_WE_N(s_we[g]), .SRAM_UB_N(s_ub[g]), .SRAM_LB_N(s_lb[g]),
            .Data_to_SRAM(s_dts[g]), .Data_drive_en(s_de[g]), .MDR_In(s_mdr[g]),
            .Mem_Ready(s_rdy[g]), .Busy(s_busy[g])
        );

        // Simple SRAM model: reads drive data only while CE/OE are low.
        logic [15:0] smem [65536];
        bit          swr  [65536];
        always_comb begin
            s_dfs[g] = 16'hDEAD;
            if (!s_ce[g] && !s_oe[g])
                s_dfs[g] = swr[s_addr[g][15:0]] ? smem[s_addr[g][15:0]] : dflt(s_addr[g][15:0]);
        end
        always @(posedge clk) begin
            if (!s_ce[g] && !s_we[g] && s_de[g]) begin
                smem[s_addr[g][15:0]] <= s_dts[g];
                swr[s_addr[g][15:0]]  <= 1'b1;
            end
        end

        bit rst_seen = 1'b1;
        always @(posedge clk) rst_seen <= !Reset;

        exp_t        expq[$];
        int          oe_lo = 0, we_lo = 0, de_n = 0;
        logic [15:0] mdr_hold = '0;

        always @(negedge clk) begin
            exp_t e;
            if (rst_seen) begin
                oe_lo = 0; we_lo = 0; de_n = 0; mdr_hold = '0;
            end
            if (!s_oe[g]) oe_lo++;
            if (!s_we[g]) we_lo++;
            if (s_de[g])  de_n++;
            if (!s_oe[g] && !s_we[g]) chk(0, "oe_we_overlap", 0, 1);
            if (s_de[g] && !s_oe[g])  chk(0, "drive_during_read", 1, 0);
            if (s_rdy[g]) begin
                if (expq.size() == 0) begin
                    chk(0, $sformatf("spurious_ready_w%0d", W), 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk((cyc - e.acc) == (e.wr ? W + 2 : W + 1),
                        $sformatf("latency_w%0d", W), cyc - e.acc, e.wr ? W + 2 : W + 1);
                    chk(s_addr[g] == e.addr, $sformatf("sram_addr_w%0d", W), s_addr[g], e.addr);
                    if (e.wr) begin
                        chk(we_lo == W, $sformatf("we_width_w%0d", W), we_lo, W);
                        chk(oe_lo == 0, $sformatf("oe_in_write_w%0d", W), oe_lo, 0);
                        chk(de_n == W + 2, $sformatf("drive_width_w%0d", W), de_n, W + 2);
                        chk(s_dts[g] == e.data, $sformatf("wdata_w%0d", W), s_dts[g], e.data);
                        chk(swr[e.addr[15:0]] && smem[e.addr[15:0]] == e.data,
                            $sformatf("sram_content_w%0d", W), smem[e.addr[15:0]], e.data);
                    end else begin
                        chk(oe_lo == W, $sformatf("oe_width_w%0d", W), oe_lo, W);
                        chk(we_lo == 0, $sformatf("we_in_read_w%0d", W), we_lo, 0);
                        chk(de_n == 0, $sformatf("drive_in_read_w%0d", W), de_n, 0);
                        chk(s_mdr[g] == e.data, $sformatf("rdata_w%0d", W), s_mdr[g], e.data);
                        mdr_hold = e.data;
                    end
                end
                oe_lo = 0; we_lo = 0; de_n = 0;
            end else if (s_mdr[g] != mdr_hold) begin
                chk(0, $sformatf("mdr_stable_w%0d", W), s_mdr[g], mdr_hold);
            end
        end
    end

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       gi[0].expq.push_back(e);
            1:       gi[1].expq.push_back(e);
            default: gi[2].expq.push_back(e);
        endcase
    endtask

    task automatic wait_idle();
        bit all_idle;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            all_idle = 1'b1;
            for (int i = 0; i < NI; i++) if (s_busy[i]) all_idle = 1'b0;
            if (all_idle) return;
        end
        chk(0, "idle_timeout", 1, 0);
    endtask

    function automatic exp_t mk_exp(input bit wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.wr   = wr;
        e.addr = {4'h0, a};
        e.acc  = cyc;
        if (wr) begin
            mmem[a] = d;
            mwr[a]  = 1'b1;
            e.data  = d;
        end else begin
            e.data  = mrd(a);
        end
        return e;
    endfunction

    // Drive one request (write wins if both strobes set), holding the level
    // for 'hold' clock edges.
    task automatic issue(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [15:0] d, input int hold);
        exp_t e;
        wait_idle();
        Mem_WE = wr; Mem_OE = rd; MAR = a; MDR = d;
        e = mk_exp(wr, a, d);
        for (int i = 0; i < NI; i++) push_exp(i, e);
        repeat (hold) @(negedge clk);
        Mem_WE = 1'b0; Mem_OE = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [15:0] a, d;
        int op, hold;

        // Reset held low for two edges with a read request pending.
        Mem_OE = 1'b1; MAR = 16'h0010;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk({s_ce[i], s_oe[i], s_we[i], s_ub[i], s_lb[i]} == 5'h1F, "rst_strobes",
                {s_ce[i], s_oe[i], s_we[i], s_ub[i], s_lb[i]}, 5'h1F);
            chk(s_busy[i] == 1'b0, "rst_busy", s_busy[i], 0);
            chk(s_rdy[i] == 1'b0, "rst_ready", s_rdy[i], 0);
            chk(s_mdr[i] == 16'h0, "rst_mdr", s_mdr[i], 0);
            chk(s_addr[i] == 20'h0, "rst_addr", s_addr[i], 0);
            chk(s_de[i] == 1'b0, "rst_drive", s_de[i], 0);
        end
        Reset = 1'b1;
        e = mk_exp(1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < NI; i++) push_exp(i, e);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(s_oe[i] == 1'b0, "post_rst_rd_act_oe", s_oe[i], 0);
            chk(s_busy[i] == 1'b1, "post_rst_busy", s_busy[i], 1);
        end
        @(negedge clk);
        Mem_OE = 1'b0;

        // Directed: write, held read-back, simultaneous strobes.
        issue(1'b1, 1'b0, 16'h0042, 16'h1234, 2);
        issue(1'b0, 1'b1, 16'h0042, 16'h0000, 6);
        issue(1'b1, 1'b1, 16'h0077, 16'hA5A5, 3);
        issue(1'b0, 1'b1, 16'h0077, 16'h0000, 20);

        // Reset during the second WE_N-low cycle of a WAIT_CYCLES=2 write.
        // Only an instance whose hold cycle lands before the reset edge
        // (completion cycle W+2 <= 3) finishes the access.
        wait_idle();
        Mem_WE = 1'b1; MAR = 16'h0123; MDR = 16'hBEEF;
        e = mk_exp(1'b1, 16'h0123, 16'hBEEF);
        for (int i = 0; i < NI; i++) if (wof(i) + 2 <= 3) push_exp(i, e);
        repeat (3) @(negedge clk);
        Reset = 1'b0; Mem_WE = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(s_we[i] == 1'b1, "abort_we_n", s_we[i], 1);
            chk(s_de[i] == 1'b0, "abort_drive", s_de[i], 0);
            chk(s_rdy[i] == 1'b0, "abort_ready", s_rdy[i], 0);
            chk(s_busy[i] == 1'b0, "abort_idle", s_busy[i], 0);
        end
        Reset = 1'b1;

        // Boundary addresses, back to back with short strobes.
        issue(1'b0, 1'b1, 16'h0000, 16'h0000, 1);
        issue(1'b1, 1'b0, 16'hFFFF, 16'h5AA5, 1);
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1);
        issue(1'b0, 1'b1, 16'h0000, 16'h0000, 1);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'h0042;
                default: a = 16'($urandom);
            endcase
            d    = 16'($urandom);
            hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(18, 21);
            issue(op != 0, op != 1, a, d, hold);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk(gi[0].expq.size() == 0, "leftover_w1", gi[0].expq.size(), 0);
        chk(gi[1].expq.size() == 0, "leftover_w2", gi[1].expq.size(), 0);
        chk(gi[2].expq.size() == 0, "leftover_w15", gi[2].expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
